// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT fetch FSM and the IF/ID pipeline register.
// Optional macro FETCH_MISALIGN_CHK_EN enables the registered misaligned-redirect flag.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [5:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_exc
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR, valid: 1'b0};

  state_t      state, state_n;
  logic [31:0] pc_q, pc_n;
  if_id_t      if_id_q, if_id_n;
  logic        mis_q, mis_n;
  logic        halted_q;
  logic [31:0] pc_plus4;
  logic [31:0] redir_aligned;
  logic        redir_mis;

  assign pc_plus4      = pc_q + 32'd4;
  assign redir_aligned = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_mis = |redirect_pc[1:0];
`else
  assign redir_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc_q     <= RESET_PC;
      if_id_q  <= BUBBLE;
      mis_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_n;
      pc_q     <= pc_n;
      if_id_q  <= if_id_n;
      mis_q    <= mis_n;
      // registered copy so halted is a flop output rather than a state decode
      halted_q <= (state_n == HALT);
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    if_id_n = if_id_q;
    mis_n   = 1'b0;
    unique case (state)
      BOOT: begin
        if_id_n = BUBBLE;
        state_n = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_n    = redir_aligned;
          if_id_n = BUBBLE;
          mis_n   = redir_mis;
        end else if (flush) begin
          if_id_n = BUBBLE;
          if (!stall) pc_n = pc_plus4;
        end else if (stall) begin
          if_id_n = if_id_q;
        end else if (imem_data == 32'h0) begin
          // an all-zero word is the halt marker; it never reaches decode
          if_id_n = BUBBLE;
          state_n = HALT;
        end else begin
          if_id_n = '{pc: pc_q, pc4: pc_plus4, instr: imem_data, valid: 1'b1};
          pc_n    = pc_plus4;
        end
      end
      HALT: begin
        if_id_n = BUBBLE;
        if (redirect) begin
          pc_n    = redir_aligned;
          mis_n   = redir_mis;
          state_n = RUN;
        end
      end
      default: begin
        state_n = BOOT;
        if_id_n = BUBBLE;
      end
    endcase
  end

  assign imem_addr    = pc_q[7:2];
  assign pc           = pc_q;
  assign if_id_pc     = if_id_q.pc;
  assign if_id_pc4    = if_id_q.pc4;
  assign if_id_instr  = if_id_q.instr;
  assign if_id_valid  = if_id_q.valid;
  assign halted       = halted_q;
  assign misalign_exc = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, boot, stall, redirect, flush, misalign flag, halt, PC wrap.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc, if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, halted, misalign_exc;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic MIS_EXP = 1'b1;
`else
  localparam logic MIS_EXP = 1'b0;
`endif

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .halted(halted), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1; redirect = 1'b1; redirect_pc = 32'h44;
    tick();
    tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if (if_id_instr !== 32'h13) begin failures++; $display("FAIL reset_instr got=%h exp=00000013", if_id_instr); end
    checks++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin failures++; $display("FAIL reset_ifid_pc got=%h/%h exp=0/0", if_id_pc, if_id_pc4); end
    checks++; if (halted !== 1'b0 || misalign_exc !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b/%b exp=0/0", halted, misalign_exc); end
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
  endtask

  task automatic test_boot();
    rst_n = 1'b1;
    tick();
    checks++; if (if_id_valid !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL boot_bubble got valid=%b pc=%h exp valid=0 pc=0", if_id_valid, pc); end
    tick();
    checks++; if (if_id_instr !== 32'h0c819c83 || if_id_valid !== 1'b1) begin failures++; $display("FAIL first_fetch_instr got=%h/%b exp=0c819c83/1", if_id_instr, if_id_valid); end
    checks++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4) begin failures++; $display("FAIL first_fetch_pc got=%h/%h exp=0/4", if_id_pc, if_id_pc4); end
    checks++; if (pc !== 32'h4 || imem_addr !== 6'd1) begin failures++; $display("FAIL first_fetch_next got pc=%h addr=%0d exp pc=4 addr=1", pc, imem_addr); end
    tick();
    checks++; if (pc !== 32'h8 || if_id_pc !== 32'h4 || if_id_instr !== 32'h10000001) begin failures++; $display("FAIL second_fetch got pc=%h ifpc=%h instr=%h exp 8/4/10000001", pc, if_id_pc, if_id_instr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== 32'h8 || imem_addr !== 6'd2 || if_id_pc !== 32'h4 || if_id_pc4 !== 32'h8 ||
          if_id_instr !== 32'h10000001 || if_id_valid !== 1'b1)
      begin failures++; $display("FAIL stall_hold%0d got pc=%h addr=%0d ifpc=%h instr=%h v=%b exp 8/2/4/10000001/1", i, pc, imem_addr, if_id_pc, if_id_instr, if_id_valid); end
    end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'hc || if_id_pc !== 32'h8 || if_id_instr !== 32'h10000002) begin failures++; $display("FAIL stall_release got pc=%h ifpc=%h instr=%h exp c/8/10000002", pc, if_id_pc, if_id_instr); end
  endtask

  task automatic test_redirect();
    stall = 1'b1; flush = 1'b1; redirect = 1'b1; redirect_pc = 32'h28;
    tick();
    stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    checks++; if (pc !== 32'h28 || imem_addr !== 6'd10) begin failures++; $display("FAIL redirect_pc got pc=%h addr=%0d exp 28/10", pc, imem_addr); end
    checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin failures++; $display("FAIL redirect_bubble got v=%b instr=%h pc=%h pc4=%h exp 0/00000013/0/0", if_id_valid, if_id_instr, if_id_pc, if_id_pc4); end
    checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL redirect_aligned_exc got=%b exp=0", misalign_exc); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    checks++; if (pc !== 32'h2c || if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin failures++; $display("FAIL flush_advance got pc=%h v=%b instr=%h exp 2c/0/00000013", pc, if_id_valid, if_id_instr); end
    stall = 1'b1;
    tick();
    checks++; if (pc !== 32'h2c || if_id_valid !== 1'b0) begin failures++; $display("FAIL flush_stall got pc=%h v=%b exp 2c/0", pc, if_id_valid); end
    flush = 1'b0; stall = 1'b0;
    tick();
    checks++; if (pc !== 32'h30 || if_id_pc !== 32'h2c || if_id_instr !== 32'h1000000b || if_id_valid !== 1'b1) begin failures++; $display("FAIL flush_resume got pc=%h ifpc=%h instr=%h exp 30/2c/1000000b", pc, if_id_pc, if_id_instr); end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h2A;
    tick();
    redirect = 1'b0;
    checks++; if (pc !== 32'h28) begin failures++; $display("FAIL misalign_pc got=%h exp=28", pc); end
    checks++; if (misalign_exc !== MIS_EXP) begin failures++; $display("FAIL misalign_flag got=%b exp=%b", misalign_exc, MIS_EXP); end
    tick();
    checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL misalign_one_cycle got=%b exp=0", misalign_exc); end
    checks++; if (pc !== 32'h2c || if_id_pc !== 32'h28 || if_id_valid !== 1'b1) begin failures++; $display("FAIL misalign_resume got pc=%h ifpc=%h v=%b exp 2c/28/1", pc, if_id_pc, if_id_valid); end
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirect_pc = 32'h4C;
    tick();
    redirect = 1'b0;
    tick();
    checks++; if (pc !== 32'h50 || if_id_pc !== 32'h4c || halted !== 1'b0) begin failures++; $display("FAIL pre_halt got pc=%h ifpc=%h h=%b exp 50/4c/0", pc, if_id_pc, halted); end
    tick();
    checks++; if (halted !== 1'b1 || pc !== 32'h50 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin failures++; $display("FAIL halt_enter got h=%b pc=%h v=%b instr=%h exp 1/50/0/00000013", halted, pc, if_id_valid, if_id_instr); end
    stall = 1'b1; flush = 1'b1;
    tick();
    tick();
    checks++; if (halted !== 1'b1 || pc !== 32'h50 || if_id_valid !== 1'b0) begin failures++; $display("FAIL halt_hold got h=%b pc=%h v=%b exp 1/50/0", halted, pc, if_id_valid); end
    stall = 1'b0; flush = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0 || pc !== 32'h0 || if_id_valid !== 1'b0) begin failures++; $display("FAIL halt_exit got h=%b pc=%h v=%b exp 0/0/0", halted, pc, if_id_valid); end
    tick();
    checks++; if (if_id_instr !== 32'h0c819c83 || pc !== 32'h4 || if_id_valid !== 1'b1) begin failures++; $display("FAIL halt_exit_fetch got instr=%h pc=%h exp 0c819c83/4", if_id_instr, pc); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFC;
    tick();
    redirect = 1'b0;
    checks++; if (pc !== 32'hfc || imem_addr !== 6'd63) begin failures++; $display("FAIL wrap_pre got pc=%h addr=%0d exp fc/63", pc, imem_addr); end
    tick();
    checks++; if (pc !== 32'h100 || imem_addr !== 6'd0) begin failures++; $display("FAIL wrap_addr got pc=%h addr=%0d exp 100/0", pc, imem_addr); end
    checks++; if (if_id_pc !== 32'hfc || if_id_pc4 !== 32'h100 || if_id_instr !== 32'h1000003f) begin failures++; $display("FAIL wrap_ifid got pc=%h pc4=%h instr=%h exp fc/100/1000003f", if_id_pc, if_id_pc4, if_id_instr); end
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFF;
    tick();
    redirect = 1'b0;
    checks++; if (pc !== 32'hfffffffc || imem_addr !== 6'd63) begin failures++; $display("FAIL top_redirect got pc=%h addr=%0d exp fffffffc/63", pc, imem_addr); end
    tick();
    checks++; if (pc !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_pc !== 32'hfffffffc || if_id_valid !== 1'b1) begin failures++; $display("FAIL pc_wrap32 got pc=%h pc4=%h ifpc=%h exp 0/0/fffffffc", pc, if_id_pc4, if_id_pc); end
  endtask

  task automatic test_reset_in_halt();
    redirect = 1'b1; redirect_pc = 32'h50;
    tick();
    redirect = 1'b0;
    tick();
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_before_reset got=%b exp=1", halted); end
    rst_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    checks++; if (pc !== 32'h0 || halted !== 1'b0 || if_id_valid !== 1'b0 || misalign_exc !== 1'b0) begin failures++; $display("FAIL reset_in_halt got pc=%h h=%b v=%b exp 0/0/0", pc, halted, if_id_valid); end
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
    tick();
    checks++; if (if_id_valid !== 1'b0 || pc !== 32'h0) begin failures++; $display("FAIL reboot_bubble got v=%b pc=%h exp 0/0", if_id_valid, pc); end
    tick();
    checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0c819c83 || pc !== 32'h4) begin failures++; $display("FAIL reboot_fetch got v=%b instr=%h pc=%h exp 1/0c819c83/4", if_id_valid, if_id_instr, pc); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h10000000 | i;
    mem[0]  = 32'h0c819c83;
    mem[20] = 32'h00000000;
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_flush();
    test_misalign();
    test_halt();
    test_wrap();
    test_reset_in_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
